// File: rtl/glip_credit_control_pkg.sv
// Shared encodings for the GLIP credit flow-control core: sender FSM states
// and bit positions inside the sticky error vector.
package glip_credit_control_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    localparam int ERR_BITS      = 4;
    localparam int ERR_OVERRUN   = 0;
    localparam int ERR_UNDERFLOW = 1;
    localparam int ERR_DEBT_OVF  = 2;
    localparam int ERR_DEBT_UNF  = 3;

endpackage

// File: rtl/glip_credit_debt.sv
// Host-granted debt counter: gates egress words, saturates on overflow and
// flags overflow / egress-without-debt as sticky errors.
module glip_credit_debt #(
    parameter int CREDIT_WIDTH = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CREDIT_WIDTH-1:0] debt_val,
    input  logic                    debt_en,
    input  logic                    transfer_egress,
    output logic                    can_send,
    output logic                    err_debt_ovf,
    output logic                    err_debt_unf
);

    localparam int DW = CREDIT_WIDTH + 1;

    logic [DW-1:0] debt;
    logic [DW:0]   debt_sum;
    logic          consume;

    // One extra bit on the sum exposes overflow directly.
    always_comb begin
        consume  = transfer_egress && (debt != '0);
        debt_sum = {1'b0, debt}
                 + (debt_en ? {2'b00, debt_val} : '0)
                 - {{DW{1'b0}}, consume};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            debt         <= '0;
            err_debt_ovf <= 1'b0;
            err_debt_unf <= 1'b0;
        end else begin
            debt <= debt_sum[DW] ? '1 : debt_sum[DW-1:0];
            if (debt_sum[DW])
                err_debt_ovf <= 1'b1;
            if (transfer_egress && (debt == '0))
                err_debt_unf <= 1'b1;
        end
    end

    assign can_send = (debt != '0);

endmodule

// File: rtl/glip_credit_control.sv
// Credit flow-control core: tracks input-FIFO credit, returns freed words to
// the host by threshold or idle timeout, and gates egress on host debt.
module glip_credit_control
    import glip_credit_control_pkg::*;
#(
    parameter int FIFO_CREDIT      = 512,
    parameter int CREDIT_WIDTH     = 15,
    parameter int RETURN_THRESHOLD = FIFO_CREDIT / 2,
    parameter int MAX_CREDIT       = 2**CREDIT_WIDTH - 1,
    parameter int IDLE_TIMEOUT     = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    transfer_in,
    input  logic                    fifo_pop,
    output logic [CREDIT_WIDTH-1:0] credit_val,
    output logic                    credit_valid,
    input  logic                    credit_ready,
    input  logic [CREDIT_WIDTH-1:0] debt_val,
    input  logic                    debt_en,
    input  logic                    transfer_egress,
    output logic                    can_send,
    output logic [ERR_BITS-1:0]     error_vec,
    output logic                    error
);

    localparam int CW = $clog2(FIFO_CREDIT + 1);
    localparam int IW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;

    localparam logic [CW-1:0] FULL_CREDIT = CW'(FIFO_CREDIT);
    localparam logic [CW-1:0] THRESH      = CW'(RETURN_THRESHOLD);
    localparam logic [CW-1:0] MSG_CAP     = (MAX_CREDIT >= FIFO_CREDIT) ? FULL_CREDIT
                                                                        : CW'(MAX_CREDIT);
    localparam logic [IW-1:0] IDLE_LAST   = (IDLE_TIMEOUT > 0) ? IW'(IDLE_TIMEOUT - 1) : '0;
    localparam bit            TIMEOUT_EN  = (IDLE_TIMEOUT != 0);

    logic [0:0]    state;
    logic [CW-1:0] granted;
    logic [CW-1:0] occupancy;
    logic [CW-1:0] freed;
    logic [IW-1:0] idle_cnt;
    logic          err_overrun;
    logic          err_underflow;
    logic          err_debt_ovf;
    logic          err_debt_unf;

    logic          in_ok;
    logic          pop_ok;
    logic          timeout_hit;
    logic          latch;
    logic [CW-1:0] msg_value;
    logic [CW-1:0] latch_amt;

    // NOTE: every signal here is assigned on every pass, so no latch is inferred.
    always_comb begin
        in_ok       = transfer_in && (granted != '0);
        pop_ok      = fifo_pop && (occupancy != '0);
        timeout_hit = TIMEOUT_EN && (freed != '0) && (idle_cnt == IDLE_LAST);
        latch       = (state == ST_IDLE) && ((freed >= THRESH) || timeout_hit);
        msg_value   = (freed > MSG_CAP) ? MSG_CAP : freed;
        latch_amt   = latch ? msg_value : '0;
    end

    // Violating transfers/pops are flagged and otherwise ignored, keeping
    // freed + granted + occupancy equal to the FIFO depth.
    // NOTE: registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            granted   <= '0;
            occupancy <= '0;
            freed     <= FULL_CREDIT;
        end else begin
            granted   <= granted + latch_amt - CW'(in_ok);
            occupancy <= occupancy + CW'(in_ok) - CW'(pop_ok);
            freed     <= freed - latch_amt + CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            credit_val <= '0;
            idle_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (latch) begin
                        state      <= ST_PEND;
                        credit_val <= CREDIT_WIDTH'(msg_value);
                    end
                end
                ST_PEND: begin
                    if (credit_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            if ((state == ST_PEND) || latch || (freed == '0))
                idle_cnt <= '0;
            else if (idle_cnt != IDLE_LAST)
                idle_cnt <= idle_cnt + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_overrun   <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            if (transfer_in && (granted == '0))
                err_overrun <= 1'b1;
            if (fifo_pop && (occupancy == '0))
                err_underflow <= 1'b1;
        end
    end

    glip_credit_debt #(
        .CREDIT_WIDTH (CREDIT_WIDTH)
    ) u_debt (
        .clk             (clk),
        .rst             (rst),
        .debt_val        (debt_val),
        .debt_en         (debt_en),
        .transfer_egress (transfer_egress),
        .can_send        (can_send),
        .err_debt_ovf    (err_debt_ovf),
        .err_debt_unf    (err_debt_unf)
    );

    assign credit_valid = (state == ST_PEND);

    always_comb begin
        error_vec                = '0;
        error_vec[ERR_OVERRUN]   = err_overrun;
        error_vec[ERR_UNDERFLOW] = err_underflow;
        error_vec[ERR_DEBT_OVF]  = err_debt_ovf;
        error_vec[ERR_DEBT_UNF]  = err_debt_unf;
    end

    assign error = |error_vec;

endmodule

// File: tb/tb_glip_credit_control.sv
// Bench for glip_credit_control: two configurations (with and without idle
// timeout) driven by shared directed stimulus and compared to a behavioural model.
module tb_glip_credit_control;

    localparam int FC   = 512;
    localparam int TH   = 256;
    localparam int DMAX = 65535;

    logic        clk = 1'b0;
    logic        rst;
    logic        transfer_in;
    logic        fifo_pop;
    logic        credit_ready;
    logic [14:0] debt_val;
    logic        debt_en;
    logic        transfer_egress;

    logic [14:0] a_credit_val,   b_credit_val;
    logic        a_credit_valid, b_credit_valid;
    logic        a_can_send,     b_can_send;
    logic [3:0]  a_error_vec,    b_error_vec;
    logic        a_error,        b_error;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    glip_credit_control #(
        .FIFO_CREDIT(512), .CREDIT_WIDTH(15), .RETURN_THRESHOLD(256),
        .MAX_CREDIT(511), .IDLE_TIMEOUT(16)
    ) dut_a (
        .clk(clk), .rst(rst), .transfer_in(transfer_in), .fifo_pop(fifo_pop),
        .credit_val(a_credit_val), .credit_valid(a_credit_valid), .credit_ready(credit_ready),
        .debt_val(debt_val), .debt_en(debt_en), .transfer_egress(transfer_egress),
        .can_send(a_can_send), .error_vec(a_error_vec), .error(a_error)
    );

    glip_credit_control #(
        .FIFO_CREDIT(512), .CREDIT_WIDTH(15), .RETURN_THRESHOLD(256),
        .MAX_CREDIT(32767), .IDLE_TIMEOUT(0)
    ) dut_b (
        .clk(clk), .rst(rst), .transfer_in(transfer_in), .fifo_pop(fifo_pop),
        .credit_val(b_credit_val), .credit_valid(b_credit_valid), .credit_ready(credit_ready),
        .debt_val(debt_val), .debt_en(debt_en), .transfer_egress(transfer_egress),
        .can_send(b_can_send), .error_vec(b_error_vec), .error(b_error)
    );

    // Abstract view of one core: word counts, pending message, debt, error set.
    typedef struct {
        int       to;
        int       maxc;
        bit       init;
        int       granted;
        int       occ;
        int       freed;
        int       idle;
        bit       pend;
        int       cval;
        int       debt;
        bit [3:0] err;
    } model_t;

    model_t ma = '{to: 16, maxc: 511,   default: 0};
    model_t mb = '{to: 0,  maxc: 32767, default: 0};

    task automatic model_step(inout model_t m, input bit r, input bit tin, input bit pop,
                              input bit rdy, input bit den, input int dval, input bit eg);
        bit tin_ok, pop_ok, go;
        int v, full, dec;
        if (r) begin
            m.init = 1; m.granted = 0; m.occ = 0; m.freed = FC; m.idle = 0;
            m.pend = 0; m.cval = 0; m.debt = 0; m.err = '0;
            return;
        end
        tin_ok = tin && (m.granted > 0);
        pop_ok = pop && (m.occ > 0);
        if (tin && m.granted == 0) m.err[0] = 1'b1;
        if (pop && m.occ == 0)     m.err[1] = 1'b1;
        go = !m.pend && (m.freed >= TH ||
                         (m.to != 0 && m.freed != 0 && m.idle == m.to - 1));
        v  = (m.freed < m.maxc) ? m.freed : m.maxc;
        if (m.pend || go || m.freed == 0) m.idle = 0;
        else if (m.to != 0 && m.idle < m.to - 1) m.idle++;
        if (m.pend) begin
            if (rdy) m.pend = 0;
        end else if (go) begin
            m.pend = 1;
            m.cval = v;
        end
        if (!go) v = 0;
        m.granted = m.granted + v - int'(tin_ok);
        m.freed   = m.freed - v + int'(pop_ok);
        m.occ     = m.occ + int'(tin_ok) - int'(pop_ok);
        dec = (eg && m.debt > 0) ? 1 : 0;
        if (eg && m.debt == 0) m.err[3] = 1'b1;
        full = m.debt + (den ? dval : 0) - dec;
        if (full > DMAX) begin
            m.debt   = DMAX;
            m.err[2] = 1'b1;
        end else begin
            m.debt = full;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_dut(input string p, input model_t m, input logic valid,
                               input logic [14:0] val, input logic cs,
                               input logic [3:0] ev, input logic e);
        check({p, ".credit_valid"}, int'(valid), int'(m.pend));
        check({p, ".credit_val"},   int'(val),   m.cval);
        check({p, ".can_send"},     int'(cs),    int'(m.debt != 0));
        check({p, ".error_vec"},    int'(ev),    int'(m.err));
        check({p, ".error"},        int'(e),     int'(m.err != 4'b0000));
    endtask

    always @(posedge clk) begin
        model_step(ma, rst, transfer_in, fifo_pop, credit_ready, debt_en, int'(debt_val), transfer_egress);
        model_step(mb, rst, transfer_in, fifo_pop, credit_ready, debt_en, int'(debt_val), transfer_egress);
    end

    always @(negedge clk) begin
        if (ma.init) begin
            compare_dut("a", ma, a_credit_valid, a_credit_val, a_can_send, a_error_vec, a_error);
            compare_dut("b", mb, b_credit_valid, b_credit_val, b_can_send, b_error_vec, b_error);
        end
    end

    task automatic reset_dut(input bit rdy);
        rst = 1'b1; transfer_in = 1'b0; fifo_pop = 1'b0; debt_en = 1'b0;
        debt_val = '0; transfer_egress = 1'b0; credit_ready = rdy;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int bcount;
        bit [2:0] cs_exp;

        // Reset release: 511 capped message, then 1 word via idle timeout.
        reset_dut(1'b1);
        check("reset.credit_valid", int'(a_credit_valid), 0);
        check("reset.credit_val",   int'(a_credit_val),   0);
        check("reset.can_send",     int'(a_can_send),     0);
        check("reset.error_vec",    int'(a_error_vec),    0);
        @(negedge clk);
        check("rel.a_val",   int'(a_credit_val), 511);
        check("rel.a_valid", int'(a_credit_valid), 1);
        check("rel.b_val",   int'(b_credit_val), 512);
        @(negedge clk);
        n = 0;
        while (!a_credit_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("rel.a_timeout_latency", n, 16);
        check("rel.a_residual_val", int'(a_credit_val), 1);
        @(negedge clk);
        check("rel.model_granted", ma.granted, 512);
        check("rel.model_freed",   ma.freed,   0);

        // Threshold: 256 in, 256 out, message two cycles after the last pop.
        reset_dut(1'b1);
        repeat (25) @(negedge clk);
        transfer_in = 1'b1;
        repeat (256) @(negedge clk);
        transfer_in = 1'b0;
        fifo_pop = 1'b1;
        repeat (256) @(negedge clk);
        fifo_pop = 1'b0;
        check("thr.b_valid_early", int'(b_credit_valid), 0);
        @(negedge clk);
        check("thr.b_valid", int'(b_credit_valid), 1);
        check("thr.b_val",   int'(b_credit_val), 256);
        @(negedge clk);
        check("thr.b_acked", int'(b_credit_valid), 0);

        // Idle timeout: 10 pops produce a partial message on A only.
        reset_dut(1'b1);
        repeat (25) @(negedge clk);
        transfer_in = 1'b1;
        repeat (10) @(negedge clk);
        transfer_in = 1'b0;
        bcount = 0;
        fifo_pop = 1'b1;
        repeat (10) begin
            @(negedge clk);
            bcount += int'(b_credit_valid);
        end
        fifo_pop = 1'b0;
        n = 0;
        while (!a_credit_valid && n < 40) begin
            @(negedge clk);
            n++;
            bcount += int'(b_credit_valid);
        end
        check("idle.a_latency", n, 7);
        check("idle.a_val", int'(a_credit_val), 10);
        repeat (30) begin
            @(negedge clk);
            bcount += int'(b_credit_valid);
        end
        check("idle.b_no_messages", bcount, 0);

        // Ack stall: message held stable, freed keeps accumulating.
        reset_dut(1'b1);
        repeat (25) @(negedge clk);
        transfer_in = 1'b1;
        repeat (300) @(negedge clk);
        transfer_in = 1'b0;
        credit_ready = 1'b0;
        fifo_pop = 1'b1;
        repeat (300) @(negedge clk);
        fifo_pop = 1'b0;
        repeat (10) @(negedge clk);
        check("stall.a_valid", int'(a_credit_valid), 1);
        check("stall.a_val",   int'(a_credit_val), 16);
        check("stall.b_valid", int'(b_credit_valid), 1);
        check("stall.b_val",   int'(b_credit_val), 256);
        credit_ready = 1'b1;
        @(negedge clk);
        check("stall.a_ack", int'(a_credit_valid), 0);
        @(negedge clk);
        check("stall.a_new_valid", int'(a_credit_valid), 1);
        check("stall.a_new_val",   int'(a_credit_val), 284);

        // Debt: 3 granted, 3 consumed, 4th flags underflow; then overflow.
        reset_dut(1'b1);
        debt_en = 1'b1; debt_val = 15'd3;
        @(negedge clk);
        debt_en = 1'b0; debt_val = '0;
        check("debt.can_send_after_grant", int'(a_can_send), 1);
        cs_exp = 3'b011;
        transfer_egress = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("debt.can_send_consume", int'(a_can_send), int'(cs_exp[i]));
        end
        @(negedge clk);
        transfer_egress = 1'b0;
        check("debt.unf_error_vec", int'(a_error_vec), 8);
        check("debt.unf_error",     int'(a_error), 1);
        repeat (5) @(negedge clk);
        check("debt.unf_sticky", int'(a_error), 1);
        debt_en = 1'b1; debt_val = 15'd32767;
        repeat (3) @(negedge clk);
        debt_en = 1'b0; debt_val = '0;
        check("debt.ovf_error_vec", int'(a_error_vec), 12);
        check("debt.ovf_can_send",  int'(a_can_send), 1);

        // Overrun and underflow on the first cycle after reset.
        reset_dut(1'b1);
        transfer_in = 1'b1; fifo_pop = 1'b1;
        @(negedge clk);
        transfer_in = 1'b0; fifo_pop = 1'b0;
        check("err.in_pop_vec", int'(a_error_vec), 3);
        check("err.in_pop_err", int'(a_error), 1);

        // Reset while a message is pending discards it.
        reset_dut(1'b0);
        @(negedge clk);
        check("rstpend.valid_before", int'(a_credit_valid), 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstpend.valid_after", int'(a_credit_valid), 0);
        check("rstpend.val_after",   int'(a_credit_val), 0);
        check("rstpend.err_after",   int'(a_error_vec), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
